// File: rtl/control_pkg.sv
// Shared opcode, state and strobe definitions for the Mini-SRC control sequencer.
package control_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    localparam logic [OP_W-1:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic reg_rr;
        logic muldiv;
        logic imm;
        logic unary;
        logic ldi;
        logic ld;
        logic st;
        logic mfhi;
        logic mflo;
        logic nop;
        logic halt;
        logic illegal;
    } class_t;

    typedef struct packed {
        logic pcout;
        logic pcin;
        logic incpc;
        logic marin;
        logic mdrin;
        logic mdrout;
        logic read;
        logic write;
        logic irin;
        logic yin;
        logic zin;
        logic zlowout;
        logic zhighout;
        logic hiin;
        logic loin;
        logic hiout;
        logic loout;
        logic cout;
        logic gra;
        logic grb;
        logic grc;
        logic rin;
        logic rout;
        logic baout;
    } strobes_t;

endpackage

// File: rtl/control_class_decode.sv
// Opcode to one-hot instruction class; anything outside the opcode table is ILLEGAL.
// Purely combinational, no latency, no flow control.
module control_class_decode
    import control_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output class_t          cls
);

    always_comb begin
        cls = '0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls.reg_rr  = 1'b1;
            OP_MUL, OP_DIV:                 cls.muldiv  = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:       cls.imm     = 1'b1;
            OP_NEG, OP_NOT:                 cls.unary   = 1'b1;
            OP_LDI:                         cls.ldi     = 1'b1;
            OP_LD:                          cls.ld      = 1'b1;
            OP_ST:                          cls.st      = 1'b1;
            OP_MFHI:                        cls.mfhi    = 1'b1;
            OP_MFLO:                        cls.mflo    = 1'b1;
            OP_NOP:                         cls.nop     = 1'b1;
            OP_HALT:                        cls.halt    = 1'b1;
            default:                        cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute sequencer for the Mini-SRC datapath; strobes decode from state + opcode.
// Memory waits hold T1/T6/T7 until mem_ready; stop diverts the instruction-final edge to HALT.
module control_sequencer
    import control_pkg::*;
#(
    parameter int OPCODE_W        = 5,
    parameter int ALU_OP_W        = 5,
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         IR_data,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                Write,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic                HIout,
    output logic                LOout,
    output logic                Cout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run
);

    state_t               state;
    state_t               state_nxt;
    state_t               done_nxt;
    logic                 pc_seen;
    logic                 alu_from_ir;
    strobes_t             s;
    class_t               cls;
    logic [OPCODE_W-1:0]  opcode;
    logic                 unused_ir;

    assign opcode    = IR_data[31 -: OPCODE_W];
    assign unused_ir = ^IR_data[31-OPCODE_W:0];

    control_class_decode u_decode (
        .opcode (OP_W'(opcode)),
        .cls    (cls)
    );

    // pc_seen is high from the second T1 cycle on, so PCin pulses once per fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_RST;
            pc_seen <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_seen <= (state == ST_T1);
        end
    end

    assign done_nxt = stop ? ST_HALT : ST_T0;

    always_comb begin
        state_nxt   = state;
        s           = '0;
        alu_from_ir = 1'b0;
        unique case (state)
            ST_RST: state_nxt = ST_T0;
            ST_T0: begin
                s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin = 1'b1;
                state_nxt = ST_T1;
            end
            ST_T1: begin
                s.zlowout = 1'b1; s.pcin = ~pc_seen; s.read = 1'b1; s.mdrin = 1'b1;
                if (mem_ready) state_nxt = ST_T2;
            end
            ST_T2: begin
                s.mdrout = 1'b1; s.irin = 1'b1;
                state_nxt = ST_T3;
            end
            ST_T3: begin
                state_nxt = ST_T4;
                unique case (1'b1)
                    cls.reg_rr, cls.muldiv, cls.imm: begin
                        s.grb = 1'b1; s.rout = 1'b1; s.yin = 1'b1;
                    end
                    cls.unary: begin
                        s.grb = 1'b1; s.rout = 1'b1; s.zin = 1'b1; alu_from_ir = 1'b1;
                    end
                    cls.ldi, cls.ld, cls.st: begin
                        s.grb = 1'b1; s.baout = 1'b1; s.yin = 1'b1;
                    end
                    cls.mfhi: begin
                        s.hiout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_nxt = done_nxt;
                    end
                    cls.mflo: begin
                        s.loout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_nxt = done_nxt;
                    end
                    cls.halt:    state_nxt = ST_HALT;
                    cls.illegal: state_nxt = HALT_ON_ILLEGAL ? ST_HALT : done_nxt;
                    default:     state_nxt = done_nxt;
                endcase
            end
            ST_T4: begin
                state_nxt = ST_T5;
                unique case (1'b1)
                    cls.reg_rr, cls.muldiv: begin
                        s.grc = 1'b1; s.rout = 1'b1; s.zin = 1'b1; alu_from_ir = 1'b1;
                    end
                    cls.imm: begin
                        s.cout = 1'b1; s.zin = 1'b1; alu_from_ir = 1'b1;
                    end
                    cls.unary: begin
                        s.zlowout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_nxt = done_nxt;
                    end
                    cls.ldi, cls.ld, cls.st: begin
                        s.cout = 1'b1; s.zin = 1'b1;
                    end
                    default: state_nxt = done_nxt;
                endcase
            end
            ST_T5: begin
                state_nxt = ST_T6;
                unique case (1'b1)
                    cls.reg_rr, cls.imm, cls.ldi: begin
                        s.zlowout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; state_nxt = done_nxt;
                    end
                    cls.muldiv: begin
                        s.zlowout = 1'b1; s.loin = 1'b1;
                    end
                    cls.ld, cls.st: begin
                        s.zlowout = 1'b1; s.marin = 1'b1;
                    end
                    default: state_nxt = done_nxt;
                endcase
            end
            ST_T6: begin
                state_nxt = done_nxt;
                unique case (1'b1)
                    cls.muldiv: begin
                        s.zhighout = 1'b1; s.hiin = 1'b1;
                    end
                    cls.ld: begin
                        s.read = 1'b1; s.mdrin = 1'b1;
                        state_nxt = mem_ready ? ST_T7 : ST_T6;
                    end
                    cls.st: begin
                        // Read stays low so MDR captures the bus (Ra) instead of memory
                        s.gra = 1'b1; s.rout = 1'b1; s.mdrin = 1'b1;
                        state_nxt = ST_T7;
                    end
                    default: state_nxt = done_nxt;
                endcase
            end
            ST_T7: begin
                state_nxt = done_nxt;
                unique case (1'b1)
                    cls.ld: begin
                        s.mdrout = 1'b1; s.gra = 1'b1; s.rin = 1'b1;
                    end
                    cls.st: begin
                        s.write = 1'b1;
                        if (!mem_ready) state_nxt = ST_T7;
                    end
                    default: state_nxt = done_nxt;
                endcase
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RST;
        endcase
    end

    assign PCout    = s.pcout;
    assign PCin     = s.pcin;
    assign IncPC    = s.incpc;
    assign MARin    = s.marin;
    assign MDRin    = s.mdrin;
    assign MDRout   = s.mdrout;
    assign Read     = s.read;
    assign Write    = s.write;
    assign IRin     = s.irin;
    assign Yin      = s.yin;
    assign Zin      = s.zin;
    assign Zlowout  = s.zlowout;
    assign Zhighout = s.zhighout;
    assign HIin     = s.hiin;
    assign LOin     = s.loin;
    assign HIout    = s.hiout;
    assign LOout    = s.loout;
    assign Cout     = s.cout;
    assign Gra      = s.gra;
    assign Grb      = s.grb;
    assign Grc      = s.grc;
    assign Rin      = s.rin;
    assign Rout     = s.rout;
    assign BAout    = s.baout;

    assign alu_op = alu_from_ir ? ALU_OP_W'(opcode) : ALU_OP_W'(ALU_ADD);
    assign run    = (state != ST_RST) && (state != ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: micro-op list model checked every cycle plus directed literal checks.
module tb_control_sequencer;

    localparam logic [23:0] PCOUT = 24'd1 << 23, PCIN = 24'd1 << 22, INCPC = 24'd1 << 21,
                            MARIN = 24'd1 << 20, MDRIN = 24'd1 << 19, MDROUT = 24'd1 << 18,
                            READ = 24'd1 << 17, WRITE = 24'd1 << 16, IRIN = 24'd1 << 15,
                            YIN = 24'd1 << 14, ZIN = 24'd1 << 13, ZLOWOUT = 24'd1 << 12,
                            ZHIGHOUT = 24'd1 << 11, HIIN = 24'd1 << 10, LOIN = 24'd1 << 9,
                            HIOUT = 24'd1 << 8, LOOUT = 24'd1 << 7, COUT = 24'd1 << 6,
                            GRA = 24'd1 << 5, GRB = 24'd1 << 4, GRC = 24'd1 << 3,
                            RIN = 24'd1 << 2, ROUT = 24'd1 << 1, BAOUT = 24'd1;
    localparam logic [4:0] ADD = 5'b00011;
    localparam logic [31:0] I_ADD = 32'h18918000, I_LD = 32'h01080055, I_ST = 32'h12000020,
                            I_MUL = 32'h72280000, I_NOP = 32'hC8000000, I_ILL = 32'hF8000000,
                            I_HALT = 32'hD0000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_data = I_ADD;
    logic        mem_ready = 1'b1;
    logic        stop = 1'b0;
    wire  [23:0] v0, v1;
    wire  [4:0]  alu0, alu1;
    wire         run0, run1;

    int tests = 0, fails = 0;
    int t1_left = 0, t6_left = 0, t7_left = 0;
    bit cmp1 = 1'b1;
    logic [23:0] lg [0:63];
    logic [4:0]  alg [0:63];
    int lidx = 0;

    always #5 clock = ~clock;

    control_sequencer #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
        .clock(clock), .reset(reset), .IR_data(IR_data), .mem_ready(mem_ready), .stop(stop),
        .PCout(v0[23]), .PCin(v0[22]), .IncPC(v0[21]), .MARin(v0[20]), .MDRin(v0[19]),
        .MDRout(v0[18]), .Read(v0[17]), .Write(v0[16]), .IRin(v0[15]), .Yin(v0[14]),
        .Zin(v0[13]), .Zlowout(v0[12]), .Zhighout(v0[11]), .HIin(v0[10]), .LOin(v0[9]),
        .HIout(v0[8]), .LOout(v0[7]), .Cout(v0[6]), .Gra(v0[5]), .Grb(v0[4]), .Grc(v0[3]),
        .Rin(v0[2]), .Rout(v0[1]), .BAout(v0[0]), .alu_op(alu0), .run(run0));

    control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
        .clock(clock), .reset(reset), .IR_data(IR_data), .mem_ready(mem_ready), .stop(stop),
        .PCout(v1[23]), .PCin(v1[22]), .IncPC(v1[21]), .MARin(v1[20]), .MDRin(v1[19]),
        .MDRout(v1[18]), .Read(v1[17]), .Write(v1[16]), .IRin(v1[15]), .Yin(v1[14]),
        .Zin(v1[13]), .Zlowout(v1[12]), .Zhighout(v1[11]), .HIin(v1[10]), .LOin(v1[9]),
        .HIout(v1[8]), .LOout(v1[7]), .Cout(v1[6]), .Gra(v1[5]), .Grb(v1[4]), .Grc(v1[3]),
        .Rin(v1[2]), .Rout(v1[1]), .BAout(v1[0]), .alu_op(alu1), .run(run1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a list of micro-steps; a step marked w holds until mem_ready.
    typedef struct packed {
        logic [23:0] s;
        logic [4:0]  alu;
        logic        w;
        logic        hlt;
    } step_t;
    step_t prog[$];
    int    midx = 0;
    int    mmode = 0;   // 0 reset, 1 running, 2 halted
    bit    mfirst = 1'b1;

    task automatic push(input logic [23:0] s, input logic [4:0] a, input bit w, input bit h);
        step_t t;
        t.s = s; t.alu = a; t.w = w; t.hlt = h;
        prog.push_back(t);
    endtask

    task automatic load_fetch();
        prog.delete();
        push(PCOUT | MARIN | INCPC | ZIN, ADD, 1'b0, 1'b0);
        push(ZLOWOUT | PCIN | READ | MDRIN, ADD, 1'b1, 1'b0);
        push(MDROUT | IRIN, ADD, 1'b0, 1'b0);
    endtask

    task automatic add_exec(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
                push(GRB | ROUT | YIN, ADD, 0, 0); push(GRC | ROUT | ZIN, op, 0, 0);
                push(ZLOWOUT | GRA | RIN, ADD, 0, 0);
            end
            5'b01110, 5'b01111: begin
                push(GRB | ROUT | YIN, ADD, 0, 0); push(GRC | ROUT | ZIN, op, 0, 0);
                push(ZLOWOUT | LOIN, ADD, 0, 0); push(ZHIGHOUT | HIIN, ADD, 0, 0);
            end
            5'b01011, 5'b01100, 5'b01101: begin
                push(GRB | ROUT | YIN, ADD, 0, 0); push(COUT | ZIN, op, 0, 0);
                push(ZLOWOUT | GRA | RIN, ADD, 0, 0);
            end
            5'b10000, 5'b10001: begin
                push(GRB | ROUT | ZIN, op, 0, 0); push(ZLOWOUT | GRA | RIN, ADD, 0, 0);
            end
            5'b00001: begin
                push(GRB | BAOUT | YIN, ADD, 0, 0); push(COUT | ZIN, ADD, 0, 0);
                push(ZLOWOUT | GRA | RIN, ADD, 0, 0);
            end
            5'b00000: begin
                push(GRB | BAOUT | YIN, ADD, 0, 0); push(COUT | ZIN, ADD, 0, 0);
                push(ZLOWOUT | MARIN, ADD, 0, 0); push(READ | MDRIN, ADD, 1, 0);
                push(MDROUT | GRA | RIN, ADD, 0, 0);
            end
            5'b00010: begin
                push(GRB | BAOUT | YIN, ADD, 0, 0); push(COUT | ZIN, ADD, 0, 0);
                push(ZLOWOUT | MARIN, ADD, 0, 0); push(GRA | ROUT | MDRIN, ADD, 0, 0);
                push(WRITE, ADD, 1, 0);
            end
            5'b10111: push(HIOUT | GRA | RIN, ADD, 0, 0);
            5'b11000: push(LOOUT | GRA | RIN, ADD, 0, 0);
            5'b11010: push(24'd0, ADD, 0, 1);
            default:  push(24'd0, ADD, 0, 0);   // nop, and illegal treated as nop
        endcase
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mmode = 0;
        end else if (mmode == 0) begin
            load_fetch(); midx = 0; mfirst = 1'b1; mmode = 1;
        end else if (mmode == 1) begin
            if (prog[midx].w && !mem_ready) begin
                mfirst = 1'b0;
            end else begin
                if (midx == 2) add_exec(IR_data[31:27]);
                if (midx == prog.size() - 1) begin
                    if (prog[midx].hlt || stop) mmode = 2;
                    else begin load_fetch(); midx = 0; end
                end else begin
                    midx++;
                end
                mfirst = 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        logic [23:0] es;
        logic [4:0]  ea;
        logic        er;
        es = '0; ea = ADD; er = 1'b0;
        if (mmode == 1) begin
            es = prog[midx].s;
            if (!mfirst) es = es & ~PCIN;
            ea = prog[midx].alu;
            er = 1'b1;
        end
        check("strobes", {8'd0, v0}, {8'd0, es});
        check("alu_op", {27'd0, alu0}, {27'd0, ea});
        check("run", {31'd0, run0}, {31'd0, er});
        if (cmp1) begin
            check("strobes_h1", {8'd0, v1}, {8'd0, es});
            check("run_h1", {31'd0, run1}, {31'd0, er});
        end
        if (lidx >= 0 && lidx < 64) begin
            lg[lidx] = v0; alg[lidx] = alu0;
        end
        if (lidx < 1000) lidx++;
    end

    // Memory responder: holds mem_ready low for the requested number of wait-state cycles.
    initial begin
        forever begin
            @(posedge clock); #1;
            if ((v0 & READ) != 0 && (v0 & ZLOWOUT) != 0 && t1_left > 0) begin
                mem_ready = 1'b0; t1_left--;
            end else if ((v0 & READ) != 0 && (v0 & ZLOWOUT) == 0 && t6_left > 0) begin
                mem_ready = 1'b0; t6_left--;
            end else if ((v0 & WRITE) != 0 && t7_left > 0) begin
                mem_ready = 1'b0; t7_left--;
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    task automatic wait_t0();
        for (int i = 0; i < 80; i++) begin
            @(negedge clock); #1;
            if ((v0 & PCOUT) != 0) return;
        end
        check("t0_timeout", 32'd0, 32'd1);
    endtask

    function automatic int cnt(input logic [23:0] need, input logic [23:0] none);
        int n = 0;
        for (int i = 1; i <= lidx - 2 && i < 64; i++)
            if ((lg[i] & need) == need && (lg[i] & none) == 0) n++;
        return n;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        t1_left = 0; t6_left = 0; t7_left = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("reset_strobes", {8'd0, v0}, 32'd0);
        check("reset_alu", {27'd0, alu0}, {27'd0, ADD});
        check("reset_run", {31'd0, run0}, 32'd0);
        @(posedge clock); #2 reset = 1'b0;

        // add r1,r2,r3
        wait_t0(); lidx = 1;
        wait_t0();
        check("add_len", lidx, 7);
        check("add_t3", {8'd0, lg[3]}, {8'd0, GRB | ROUT | YIN});
        check("add_t4", {8'd0, lg[4]}, {8'd0, GRC | ROUT | ZIN});
        check("add_t4_alu", {27'd0, alg[4]}, 32'd3);
        check("add_t5", {8'd0, lg[5]}, {8'd0, ZLOWOUT | GRA | RIN});

        // ld r2,0x55(r1) with fetch wait 2 and T6 wait 3
        IR_data = I_LD; t1_left = 2; t6_left = 3; lidx = 1;
        wait_t0();
        check("ld_pcin_once", cnt(PCIN, 24'd0), 1);
        check("ld_t1_cycles", cnt(READ | ZLOWOUT, 24'd0), 3);
        check("ld_t6_cycles", cnt(READ | MDRIN, ZLOWOUT), 4);
        check("ld_t7", {8'd0, lg[lidx-2]}, {8'd0, MDROUT | GRA | RIN});

        // st with two write-wait cycles
        IR_data = I_ST; t7_left = 2; lidx = 1;
        wait_t0();
        check("st_write_cycles", cnt(WRITE, 24'd0), 3);
        check("st_no_rin", cnt(RIN, 24'd0), 0);
        check("st_t6", {8'd0, lg[lidx-5]}, {8'd0, GRA | ROUT | MDRIN});

        // mul r4,r5
        IR_data = I_MUL; lidx = 1;
        wait_t0();
        check("mul_len", lidx, 8);
        check("mul_alu", {27'd0, alg[4]}, 32'b01110);
        check("mul_t5", {8'd0, lg[5]}, {8'd0, ZLOWOUT | LOIN});
        check("mul_t6", {8'd0, lg[6]}, {8'd0, ZHIGHOUT | HIIN});

        // nop
        IR_data = I_NOP; lidx = 1;
        wait_t0();
        check("nop_len", lidx, 5);
        check("nop_t3", {8'd0, lg[3]}, 32'd0);

        // illegal: nop on dut0, HALT on dut1
        IR_data = I_ILL; lidx = 1; cmp1 = 1'b0;
        wait_t0();
        check("ill_len", lidx, 5);
        check("ill_t3", {8'd0, lg[3]}, 32'd0);
        check("ill_h1_run", {31'd0, run1}, 32'd0);
        check("ill_h1_strobes", {8'd0, v1}, 32'd0);

        // stop raised during add T5
        IR_data = I_ADD;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 12 && !seen; i++) begin
                @(negedge clock); #1;
                if (v0 == (ZLOWOUT | GRA | RIN)) seen = 1'b1;
            end
            check("stop_t5_seen", {31'd0, seen}, 32'd1);
        end
        stop = 1'b1;
        @(negedge clock); #1;
        check("stop_halt_run", {31'd0, run0}, 32'd0);
        check("stop_halt_strobes", {8'd0, v0}, 32'd0);

        // halt instruction; HALT must persist while stop toggles
        @(negedge clock); #1;
        IR_data = I_HALT; stop = 1'b0; cmp1 = 1'b1;
        pulse_reset();
        wait_t0();
        begin
            int n = 0;
            for (int i = 1; i <= 10; i++) begin
                @(negedge clock); #1;
                if (!run0 && n == 0) n = i;
            end
            check("halt_entry", n, 4);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #2 stop = ~stop;
            @(negedge clock); #1;
            check("halt_hold", {7'd0, run0, v0}, 32'd0);
        end
        stop = 1'b0;

        // reset asserted between edges while st waits in T7
        IR_data = I_ST;
        pulse_reset();
        t7_left = 1000;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clock); #1;
                if ((v0 & WRITE) != 0) seen = 1'b1;
            end
            check("rst_write_seen", {31'd0, seen}, 32'd1);
        end
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check("rst_write_drop", {8'd0, v0 & WRITE}, 32'd0);
        check("rst_run_drop", {31'd0, run0}, 32'd0);
        t7_left = 0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock); #1;
        check("rst_rst_state", {7'd0, run0, v0}, 32'd0);
        @(negedge clock); #1;
        check("rst_then_t0", {8'd0, v0}, {8'd0, PCOUT | MARIN | INCPC | ZIN});
        check("rst_then_run", {31'd0, run0}, 32'd1);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
